// File: rtl/step_coil_driver.sv
// rtl/step_coil_driver.sv - stepper coil sequencer with dwell, one-deep request queue and enable gating
// Optional half-step sequencing when STEP_COIL_HALF_STEP_EN is defined.
module step_coil_driver #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] st,
    input  logic       dir,
    input  logic       en,
    output logic [3:0] coil,
    output logic       busy,
    output logic [7:0] pos,
    output logic       ovf
);

`ifdef STEP_COIL_HALF_STEP_EN
    localparam int PW = 3;

    function automatic logic [3:0] pattern(input logic [PW-1:0] p);
        case (p)
            3'd0:    pattern = 4'b0001;
            3'd1:    pattern = 4'b0011;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b1100;
            3'd6:    pattern = 4'b1000;
            default: pattern = 4'b1001;
        endcase
    endfunction
`else
    localparam int PW = 2;

    function automatic logic [3:0] pattern(input logic [PW-1:0] p);
        case (p)
            2'd0:    pattern = 4'b0011;
            2'd1:    pattern = 4'b0110;
            2'd2:    pattern = 4'b1100;
            default: pattern = 4'b1001;
        endcase
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      st_q;
    logic            en_q;
    logic [PW-1:0]   phase, phase_nxt;
    logic [7:0]      pos_nxt;
    logic [7:0]      dcnt;
    logic            pending;
    logic            energised, energised_nxt;
    logic            req;

    assign req  = en & (st != st_q);
    assign busy = (state == STEP) || (state == HOLD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req || (en && pending)) state_nxt = STEP;
            STEP:    state_nxt = HOLD;
            HOLD:    if (dcnt == 8'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A step only moves the rotor while enabled; coils stay dark after reset
    // until a step completes or enable is re-asserted.
    always_comb begin
        phase_nxt     = phase;
        pos_nxt       = pos;
        energised_nxt = energised | (en & ~en_q);
        if (state == STEP && en) begin
            phase_nxt     = dir ? phase + 1'b1 : phase - 1'b1;
            pos_nxt       = dir ? pos + 8'd1 : pos - 8'd1;
            energised_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            st_q      <= st;
            en_q      <= en;
            phase     <= '0;
            pos       <= 8'd0;
            coil      <= 4'b0000;
            ovf       <= 1'b0;
            pending   <= 1'b0;
            dcnt      <= 8'd0;
            energised <= 1'b0;
        end else begin
            state     <= state_nxt;
            st_q      <= st;
            en_q      <= en;
            phase     <= phase_nxt;
            pos       <= pos_nxt;
            energised <= energised_nxt;
            coil      <= (en && energised_nxt) ? pattern(phase_nxt) : 4'b0000;

            case (state)
                STEP:    dcnt <= 8'(DWELL - 1);
                HOLD:    if (dcnt != 8'd0) dcnt <= dcnt - 8'd1;
                default: dcnt <= 8'd0;
            endcase

            // In IDLE a pending request is consumed; a coincident new one re-arms it.
            if (state == IDLE) begin
                pending <= req & pending;
            end else if (req) begin
                if (pending) ovf <= 1'b1;
                else         pending <= 1'b1;
            end else if (state == HOLD && dcnt == 8'd0 && !en) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/step_coil_driver.md
STEP_COIL_DRIVER -- requirements
Module: step_coil_driver

Interface
REQ-001 SHALL have parameter DWELL, default 4, giving the coil hold time in clk cycles after each step (legal range 1-255).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port st  input  4  step index from the upstream step counter; any change in its value is one step request.
REQ-005 SHALL have port dir  input  1  step direction: 1 = forward, 0 = reverse.
REQ-006 SHALL have port en  input  1  driver enable; 0 de-energises the coils.
REQ-007 SHALL have port coil  output  4  coil energise pattern {D,C,B,A}.
REQ-008 SHALL have port busy  output  1  high while the driver is in state STEP or HOLD.
REQ-009 SHALL have port pos  output  8  signed-agnostic step position counter.
REQ-010 SHALL have port ovf  output  1  sticky flag: a step request was dropped.

Function
REQ-011 SHALL register st into st_q every cycle; req = en & (st != st_q).
REQ-012 SHALL implement the FSM IDLE -> STEP -> HOLD -> IDLE.
- IDLE: on req or pending, go to STEP.
- STEP: lasts exactly one cycle; goes to HOLD.
- HOLD: dwell counter loads DWELL-1; returns to IDLE when the counter is 0.
REQ-013 SHALL, in STEP, set phase = phase+1 when dir=1 and phase-1 when dir=0 (modulo table length), and set pos = pos+1 or pos-1 (8-bit wrap: 255+1 -> 0, 0-1 -> 255).
REQ-014 SHALL sample dir in the STEP cycle, not at request time.
REQ-015 SHALL drive coil from phase with a 1-cycle registered latency: coil changes in the cycle after STEP.
REQ-016 SHALL use the full-step table, indexed 0..3: 0011, 0110, 1100, 1001.
REQ-017 SHALL set busy=1 from the STEP cycle through the last HOLD cycle, so busy is high for 1+DWELL cycles per step.
REQ-018 SHALL, when req occurs in STEP or HOLD, set a one-deep pending flag.
REQ-019 SHALL, when req occurs while pending is already set, drop that request and set ovf=1; ovf is cleared only by rst.
REQ-020 SHALL clear pending in the IDLE -> STEP transition that consumes it.
REQ-021 SHALL, when req and pending consumption coincide in IDLE, consume one request and set pending again for the other.
REQ-022 SHALL, when en=0, ignore requests while st_q keeps tracking st, and hold phase and pos.
REQ-023 SHALL, when en=0, force coil=0000 from the next cycle.
REQ-024 SHALL, when en falls during STEP or HOLD, let the FSM finish its dwell, then clear pending.
REQ-025 SHALL, when en returns to 1, restore coil to table[phase] one cycle later.

Reset
REQ-026 SHALL, while rst=1, load: state=IDLE, st_q=st, phase=0, pos=0, coil=0000, busy=0, ovf=0, pending=0, dwell counter=0.
REQ-027 SHALL, when rst is asserted mid-STEP or mid-HOLD, abort that step at the next edge, discard any pending request and leave no partial step.
REQ-028 SHALL, after reset, hold coil=0000 until the first completed step, or until an en 0 -> 1 edge with en sampled high.

Configuration
REQ-029 SHALL support macro STEP_COIL_HALF_STEP_EN.
- Defined: phase is 3 bits over the 8-entry half-step table 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001; each step advances phase by one entry and pos by one.
- Undefined: phase is 2 bits over the full-step table of REQ-016; there is no half-step logic.

Verification
REQ-030 SHALL cover: reset, then en=1, dir=1, st 0->1, DWELL=4 -> busy high for 5 cycles, coil=0110, pos=1.
REQ-031 SHALL cover: dir=0 from reset with one step -> phase=3, coil=1001, pos=255; then four forward steps -> pos=3, coil=1001.
REQ-032 SHALL cover: three st changes on consecutive cycles -> two steps executed (pos=2), ovf=1, ovf still 1 after 20 idle cycles.
REQ-033 SHALL cover: en=0 mid-HOLD with a pending request -> dwell completes, pending discarded, coil=0000, pos unchanged after further st changes.
REQ-034 SHALL cover: rst pulse in the second HOLD cycle -> next cycle coil=0000, pos=0, busy=0, ovf=0.
REQ-035 SHALL cover: STEP_COIL_HALF_STEP_EN defined, 8 forward steps -> coil sequence 0011, 0010, 0110, 0100, 1100, 1000, 1001, 0001, pos=8.
